// File: rtl/ecc_sed_decoder_if.sv
// Handshake bundle for the SED parity decoder.
//   enc_*  : upstream codeword stream (13-bit even-parity codeword in)
//   dec_*  : downstream payload stream (12-bit data + per-word error flag out)
// Modports:
//   slave  : decoder view (consumes enc_*, produces dec_*)
//   master : environment view (produces enc_*, consumes dec_*)
interface ecc_sed_decoder_if;
  logic        enc_valid;
  logic        enc_ready;
  logic [12:0] enc_codeword;
  logic        dec_valid;
  logic        dec_ready;
  logic [11:0] dec_data;
  logic        dec_error;

  modport slave (
    input  enc_valid, enc_codeword, dec_ready,
    output enc_ready, dec_valid, dec_data, dec_error
  );

  modport master (
    output enc_valid, enc_codeword, dec_ready,
    input  enc_ready, dec_valid, dec_data, dec_error
  );
endinterface

// File: rtl/ecc_sed_decoder.sv
// Single-error-detect (even parity) decoder with a two-entry output buffer.
// Checks each accepted 13-bit codeword, passes the 12-bit payload through
// unmodified with a per-word error flag, and keeps sticky/saturating status.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : enc_* input stream and dec_* output stream (slave modport)
//   err_clear   : one-cycle pulse clearing err_sticky and err_count
//   err_sticky  : set by any accepted word with a parity error
//   err_count   : accepted words with a parity error, saturating
//   word_count  : total accepted words, saturating
//
// state | meaning
// EMPTY | nothing buffered
// ONE   | OUT holds a valid word
// TWO   | OUT and SKID both valid; upstream stalled
module ecc_sed_decoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_sed_decoder_if.slave     bus,
  input  logic                 err_clear,
  output logic                 err_sticky,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] word_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t      state, state_nxt;
  logic [11:0] out_data, skid_data;
  logic        out_err, skid_err;
  logic        acc, drn, syndrome;
  logic        ld_out_in, ld_out_skid, ld_skid;

  assign syndrome      = ^bus.enc_codeword;
  assign bus.enc_ready = (state != TWO) && !rst;
  assign bus.dec_valid = (state != EMPTY);
  assign bus.dec_data  = out_data;
  assign bus.dec_error = out_err;
  assign acc = bus.enc_valid && bus.enc_ready;
  assign drn = bus.dec_valid && bus.dec_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          ld_out_in = 1'b1;
        end
      end
      ONE: begin
        if (acc && !drn) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (acc && drn) begin
          ld_out_in = 1'b1;
        end else if (drn) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (drn) begin
          state_nxt   = ONE;
          ld_out_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (ld_out_in) begin
        out_data <= bus.enc_codeword[11:0];
        out_err  <= syndrome;
      end else if (ld_out_skid) begin
        out_data <= skid_data;
        out_err  <= skid_err;
      end
      if (ld_skid) begin
        skid_data <= bus.enc_codeword[11:0];
        skid_err  <= syndrome;
      end
    end
  end

  // A new error on the same edge as err_clear wins: count restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (acc && !(&word_count)) word_count <= word_count + CNT_ONE;
      if (acc && syndrome) begin
        err_sticky <= 1'b1;
        if (err_clear)          err_count <= CNT_ONE;
        else if (!(&err_count)) err_count <= err_count + CNT_ONE;
      end else if (err_clear) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ecc_sed_decoder.sv
module tb_ecc_sed_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clear, err_sticky;
  logic [15:0] err_count, word_count;
  logic        err_clear4, err_sticky4;
  logic [3:0]  err_count4, word_count4;

  int checks = 0;
  int failures = 0;

  ecc_sed_decoder_if bus ();
  ecc_sed_decoder_if bus4 ();

  ecc_sed_decoder #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_clear(err_clear),
    .err_sticky(err_sticky), .err_count(err_count), .word_count(word_count)
  );

  ecc_sed_decoder #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .err_clear(err_clear4),
    .err_sticky(err_sticky4), .err_count(err_count4), .word_count(word_count4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [12:0] cw;
    logic [11:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_errs;

    vecs[0] = '{13'h0000, 12'h000, 1'b0};
    vecs[1] = '{13'h1001, 12'h001, 1'b0};
    vecs[2] = '{13'h0FFF, 12'hFFF, 1'b0};
    vecs[3] = '{13'h0001, 12'h001, 1'b1};
    vecs[4] = '{13'h1FFF, 12'hFFF, 1'b1};
    vecs[5] = '{13'h1000, 12'h000, 1'b1};
    vecs[6] = '{13'h0003, 12'h003, 1'b0};
    vecs[7] = '{13'h0ABC, 12'hABC, 1'b1};

    rst = 1'b1;
    err_clear = 1'b0;
    bus.enc_valid = 1'b1;
    bus.enc_codeword = 13'h0001;
    bus.dec_ready = 1'b0;
    err_clear4 = 1'b0;
    bus4.enc_valid = 1'b0;
    bus4.enc_codeword = 13'h0000;
    bus4.dec_ready = 1'b1;

    // Reset state, with enc_valid ignored during reset
    tick();
    tick();
    chk("rst_enc_ready", bus.enc_ready, 0);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_dec_data", bus.dec_data, 0);
    chk("rst_dec_error", bus.dec_error, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_sticky", err_sticky, 0);
    rst = 1'b0;
    bus.enc_valid = 1'b0;
    #1;
    chk("post_rst_enc_ready", bus.enc_ready, 1);

    // Streaming vectors with dec_ready held high
    bus.dec_ready = 1'b1;
    exp_errs = 0;
    for (int i = 0; i < 8; i++) begin
      bus.enc_valid = 1'b1;
      bus.enc_codeword = vecs[i].cw;
      chk($sformatf("vec%0d_enc_ready", i), bus.enc_ready, 1);
      tick();
      if (vecs[i].err) exp_errs++;
      chk($sformatf("vec%0d_dec_valid", i), bus.dec_valid, 1);
      chk($sformatf("vec%0d_dec_data", i), bus.dec_data, vecs[i].data);
      chk($sformatf("vec%0d_dec_error", i), bus.dec_error, vecs[i].err);
      chk($sformatf("vec%0d_word_count", i), word_count, i + 1);
      chk($sformatf("vec%0d_err_count", i), err_count, exp_errs);
      chk($sformatf("vec%0d_err_sticky", i), err_sticky, exp_errs != 0);
    end
    bus.enc_valid = 1'b0;
    tick();
    chk("drain_dec_valid", bus.dec_valid, 0);
    chk("stream_word_count", word_count, 8);
    chk("stream_err_count", err_count, 4);

    // err_clear alone
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clr_err_sticky", err_sticky, 0);
    chk("clr_err_count", err_count, 0);
    chk("clr_word_count", word_count, 8);

    // err_clear coincident with an erroneous accept
    err_clear = 1'b1;
    bus.enc_valid = 1'b1;
    bus.enc_codeword = 13'h0001;
    tick();
    err_clear = 1'b0;
    bus.enc_valid = 1'b0;
    chk("clr_acc_err_count", err_count, 1);
    chk("clr_acc_err_sticky", err_sticky, 1);
    chk("clr_acc_word_count", word_count, 9);
    chk("clr_acc_dec_error", bus.dec_error, 1);
    tick();

    // Backpressure: three words offered, two absorbed, order kept
    bus.dec_ready = 1'b0;
    bus.enc_valid = 1'b1;
    bus.enc_codeword = 13'h0123;
    tick();
    chk("bp_w1_data", bus.dec_data, 12'h123);
    chk("bp_w1_ready", bus.enc_ready, 1);
    bus.enc_codeword = 13'h0456;
    tick();
    chk("bp_two_ready", bus.enc_ready, 0);
    chk("bp_two_data", bus.dec_data, 12'h123);
    bus.enc_codeword = 13'h0789;
    tick();
    chk("bp_stall_ready", bus.enc_ready, 0);
    chk("bp_stall_data", bus.dec_data, 12'h123);
    chk("bp_stall_error", bus.dec_error, 0);
    chk("bp_stall_valid", bus.dec_valid, 1);
    chk("bp_stall_word_count", word_count, 11);
    bus.dec_ready = 1'b1;
    tick();
    chk("bp_w2_data", bus.dec_data, 12'h456);
    chk("bp_w2_error", bus.dec_error, 1);
    chk("bp_w2_valid", bus.dec_valid, 1);
    tick();
    bus.enc_valid = 1'b0;
    chk("bp_w3_data", bus.dec_data, 12'h789);
    chk("bp_w3_error", bus.dec_error, 0);
    tick();
    chk("bp_empty_valid", bus.dec_valid, 0);
    chk("bp_word_count", word_count, 12);
    chk("bp_err_count", err_count, 2);

    // Reset while in TWO
    bus.dec_ready = 1'b0;
    bus.enc_valid = 1'b1;
    bus.enc_codeword = 13'h1111;
    tick();
    bus.enc_codeword = 13'h0222;
    tick();
    chk("rt_two_ready", bus.enc_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.enc_valid = 1'b0;
    #1;
    chk("rt_dec_valid", bus.dec_valid, 0);
    chk("rt_dec_data", bus.dec_data, 0);
    chk("rt_word_count", word_count, 0);
    chk("rt_err_count", err_count, 0);
    chk("rt_err_sticky", err_sticky, 0);
    chk("rt_enc_ready", bus.enc_ready, 1);
    bus.dec_ready = 1'b1;
    bus.enc_valid = 1'b1;
    bus.enc_codeword = 13'h0FFF;
    tick();
    bus.enc_valid = 1'b0;
    chk("rt_next_valid", bus.dec_valid, 1);
    chk("rt_next_data", bus.dec_data, 12'hFFF);
    chk("rt_next_word_count", word_count, 1);

    // Saturation with 4-bit counters
    bus4.enc_valid = 1'b1;
    bus4.enc_codeword = 13'h0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 15) begin
        chk("sat16_word_count", word_count4, 15);
        chk("sat16_err_count", err_count4, 15);
      end
    end
    bus4.enc_valid = 1'b0;
    chk("sat_word_count", word_count4, 15);
    chk("sat_err_count", err_count4, 15);
    chk("sat_err_sticky", err_sticky4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
